// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: stall vector layout and encodings,
// multi-cycle FSM states, default latencies and pc width.
package pipeline_ctrl_pkg;

    localparam int PC_W    = 32;
    localparam int STALL_W = 6;

    localparam int STALL_PC     = 0;
    localparam int STALL_IF_ID  = 1;
    localparam int STALL_ID_EX  = 2;
    localparam int STALL_EX_MEM = 3;
    localparam int STALL_MEM_WB = 4;
    localparam int STALL_WB     = 5;

    localparam logic [STALL_W-1:0] STALL_NONE    = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_ID_ENC  = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX_ENC  = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM_ENC = 6'b011111;

    localparam int MUL_LAT_DEF = 3;
    localparam int DIV_LAT_DEF = 34;
    localparam int CNT_W_DEF   = 6;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_RUN  = 2'd1,
        MC_DONE = 2'd2
    } mc_state_e;

    // Priority: flush > mem wait > ex hold > load-use. Flush freezes nothing.
    function automatic logic [STALL_W-1:0] stall_select(
        input logic flush_req,
        input logic mem_req,
        input logic ex_hold,
        input logic id_req
    );
        logic [STALL_W-1:0] enc;
        if (flush_req) begin
            enc = STALL_NONE;
        end else if (mem_req) begin
            enc = STALL_MEM_ENC;
        end else if (ex_hold) begin
            enc = STALL_EX_ENC;
        end else if (id_req) begin
            enc = STALL_ID_ENC;
        end else begin
            enc = STALL_NONE;
        end
        return enc;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_mc_counter.sv
// Loadable down-counter with a last-count flag; times multi-cycle execute ops.
module mc_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_r;

    // Count register: clear beats load beats decrement; never wraps below zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= CNT_ZERO;
        end else if (clr) begin
            cnt_r <= CNT_ZERO;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != CNT_ZERO)) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt  = cnt_r;
    assign done = (cnt_r == CNT_ONE);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central 5-stage pipeline sequencer: stall vector, flush/redirect and the
// multi-cycle execute timer so the ex unit carries no FSM of its own.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_id,
    input  logic               ex_mc_start,
    input  logic               ex_mc_is_div,
    input  logic               stallreq_mem,
    input  logic               flush_req,
    input  logic [PC_W-1:0]    flush_pc_i,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic [PC_W-1:0]    new_pc,
    output logic               mc_busy,
    output logic               mc_finish,
    output logic [CNT_W-1:0]   mc_cnt,
    output logic [31:0]        stall_cycles
);

    // The op is held in ex on the start cycle too, so the counter starts at L-1.
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    mc_state_e          state_r;
    mc_state_e          next_state_s;
    logic               mc_finish_r;
    logic [31:0]        stall_cycles_r;
    logic               ex_hold_s;
    logic               cnt_load_s;
    logic               cnt_dec_s;
    logic               cnt_clr_s;
    logic               cnt_done_s;
    logic [CNT_W-1:0]   cnt_s;
    logic [CNT_W-1:0]   load_val_s;
    logic [STALL_W-1:0] stall_s;
    logic               flush_s;
    logic [PC_W-1:0]    new_pc_s;

    mc_counter #(
        .CNT_W(CNT_W)
    ) u_mc_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr_s),
        .load     (cnt_load_s),
        .load_val (load_val_s),
        .dec      (cnt_dec_s),
        .cnt      (cnt_s),
        .done     (cnt_done_s)
    );

    assign ex_hold_s  = (state_r == MC_RUN) || ((state_r == MC_IDLE) && ex_mc_start);
    assign load_val_s = ex_mc_is_div ? DIV_CNT : MUL_CNT;

    // Next-state and counter control; a flush aborts any op in flight.
    always_comb begin
        next_state_s = MC_IDLE;
        cnt_load_s   = 1'b0;
        cnt_dec_s    = 1'b0;
        cnt_clr_s    = 1'b0;
        if (flush_req) begin
            next_state_s = MC_IDLE;
            cnt_clr_s    = 1'b1;
        end else begin
            case (state_r)
                MC_IDLE: begin
                    if (ex_mc_start) begin
                        cnt_load_s   = 1'b1;
                        next_state_s = MC_RUN;
                    end else begin
                        next_state_s = MC_IDLE;
                    end
                end
                MC_RUN: begin
                    cnt_dec_s = 1'b1;
                    if (cnt_done_s) begin
                        next_state_s = MC_DONE;
                    end else begin
                        next_state_s = MC_RUN;
                    end
                end
                MC_DONE: begin
                    // ex_mc_start still belongs to the finishing op here.
                    if (stallreq_mem) begin
                        next_state_s = MC_DONE;
                    end else begin
                        next_state_s = MC_IDLE;
                    end
                end
                default: begin
                    next_state_s = MC_IDLE;
                    cnt_clr_s    = 1'b1;
                end
            endcase
        end
    end

    // Combinational pipeline controls, forced quiet while reset is asserted.
    always_comb begin
        stall_s  = STALL_NONE;
        flush_s  = 1'b0;
        new_pc_s = {PC_W{1'b0}};
        if (!rst) begin
            stall_s  = STALL_NONE;
            flush_s  = 1'b0;
            new_pc_s = {PC_W{1'b0}};
        end else begin
            stall_s  = stall_select(flush_req, stallreq_mem, ex_hold_s, stallreq_id);
            flush_s  = flush_req;
            new_pc_s = flush_req ? flush_pc_i : {PC_W{1'b0}};
        end
    end

    // FSM state and finish flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= MC_IDLE;
            mc_finish_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            mc_finish_r <= (next_state_s == MC_DONE);
        end
    end

    // Saturating stall-cycle counter; deliberately survives flushes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_r <= 32'h0000_0000;
        end else if ((stall_s != STALL_NONE) && (stall_cycles_r != 32'hFFFF_FFFF)) begin
            stall_cycles_r <= stall_cycles_r + 32'h0000_0001;
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    assign stall        = stall_s;
    assign flush        = flush_s;
    assign new_pc       = new_pc_s;
    assign mc_busy      = (state_r == MC_RUN);
    assign mc_finish    = mc_finish_r;
    assign mc_cnt       = cnt_s;
    assign stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized
// traffic against a cycle-level model of hold/finish timing.
module tb_pipeline_ctrl;

    localparam int CNT_W = 6;
    localparam int MUL_L = 3;
    localparam int DIV_L = 34;

    logic             clk = 1'b0;
    logic             rst;
    logic             stallreq_id, ex_mc_start, ex_mc_is_div, stallreq_mem, flush_req;
    logic [31:0]      flush_pc_i;
    logic [5:0]       stall;
    logic             flush, mc_busy, mc_finish;
    logic [31:0]      new_pc, stall_cycles;
    logic [CNT_W-1:0] mc_cnt;

    int n_pass   = 0;
    int n_checks = 0;

    // Model: hold cycles left after the start cycle, finish phase flag, stall count.
    int     m_hold_left;
    bit     m_fin;
    longint m_sc;

    pipeline_ctrl #(.MUL_LAT(MUL_L), .DIV_LAT(DIV_L), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_mc_start(ex_mc_start),
        .ex_mc_is_div(ex_mc_is_div), .stallreq_mem(stallreq_mem), .flush_req(flush_req),
        .flush_pc_i(flush_pc_i), .stall(stall), .flush(flush), .new_pc(new_pc),
        .mc_busy(mc_busy), .mc_finish(mc_finish), .mc_cnt(mc_cnt), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    function automatic logic [5:0] exp_stall();
        bit hold;
        hold = (m_hold_left > 0) || (!m_fin && ex_mc_start);
        if (!rst || flush_req) return 6'b000000;
        if (stallreq_mem)      return 6'b011111;
        if (hold)              return 6'b001111;
        if (stallreq_id)       return 6'b000111;
        return 6'b000000;
    endfunction

    task automatic model_reset();
        m_hold_left = 0;
        m_fin       = 1'b0;
        m_sc        = 0;
    endtask

    task automatic drive(input bit id, input bit st, input bit dv, input bit mem,
                         input bit fl, input logic [31:0] pc);
        stallreq_id  = id;
        ex_mc_start  = st;
        ex_mc_is_div = dv;
        stallreq_mem = mem;
        flush_req    = fl;
        flush_pc_i   = pc;
    endtask

    // Update the model with this cycle's inputs, then step past the clock edge.
    task automatic advance();
        bit idle_m;
        if (exp_stall() != 6'b000000 && m_sc < 64'h0000_0000_FFFF_FFFF) m_sc++;
        idle_m = (m_hold_left == 0) && !m_fin;
        if (flush_req) begin
            m_hold_left = 0;
            m_fin       = 1'b0;
        end else if (idle_m && ex_mc_start) begin
            m_hold_left = (ex_mc_is_div ? DIV_L : MUL_L) - 1;
        end else if (m_hold_left > 0) begin
            m_hold_left--;
            if (m_hold_left == 0) m_fin = 1'b1;
        end else if (m_fin) begin
            m_fin = stallreq_mem;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        model_reset();
        #2;
        n_checks++; if (stall !== 6'b0) $display("FAIL reset_stall got %b exp 000000", stall); else n_pass++;
        n_checks++; if (flush !== 1'b0) $display("FAIL reset_flush got %b exp 0", flush); else n_pass++;
        n_checks++; if (new_pc !== 32'h0) $display("FAIL reset_new_pc got %h exp 0", new_pc); else n_pass++;
        n_checks++; if (mc_cnt !== 6'd0) $display("FAIL reset_mc_cnt got %0d exp 0", mc_cnt); else n_pass++;
        n_checks++; if (mc_finish !== 1'b0 || mc_busy !== 1'b0)
            $display("FAIL reset_mc_flags got fin=%b busy=%b exp 0/0", mc_finish, mc_busy); else n_pass++;
        n_checks++; if (stall_cycles !== 32'h0) $display("FAIL reset_stall_cycles got %0d exp 0", stall_cycles); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_use();
        longint sc0 = m_sc;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        n_checks++; if (stall !== 6'b000111) $display("FAIL load_use_stall got %b exp 000111", stall); else n_pass++;
        advance();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        n_checks++; if (stall !== 6'b000000) $display("FAIL load_use_release got %b exp 000000", stall); else n_pass++;
        n_checks++; if (stall_cycles !== 32'(sc0 + 1))
            $display("FAIL load_use_count got %0d exp %0d", stall_cycles, sc0 + 1); else n_pass++;
        advance();
    endtask

    task automatic test_divide();
        longint sc0 = m_sc;
        for (int k = 0; k < 36; k++) begin
            drive(1'b0, (k < 35), 1'b1, 1'b0, 1'b0, 32'h0);
            @(negedge clk);
            n_checks++; if (stall !== ((k < DIV_L) ? 6'b001111 : 6'b000000))
                $display("FAIL div_stall k=%0d got %b", k, stall); else n_pass++;
            n_checks++; if (mc_finish !== (k == DIV_L))
                $display("FAIL div_finish k=%0d got %b exp %b", k, mc_finish, (k == DIV_L)); else n_pass++;
            n_checks++; if (mc_busy !== (k >= 1 && k < DIV_L))
                $display("FAIL div_busy k=%0d got %b", k, mc_busy); else n_pass++;
            if (k >= 1 && k < DIV_L) begin
                n_checks++; if (mc_cnt !== CNT_W'(DIV_L - k))
                    $display("FAIL div_cnt k=%0d got %0d exp %0d", k, mc_cnt, DIV_L - k); else n_pass++;
            end
            advance();
        end
        n_checks++; if (stall_cycles !== 32'(sc0 + 34))
            $display("FAIL div_stall_cycles got %0d exp %0d", stall_cycles, sc0 + 34); else n_pass++;
    endtask

    task automatic test_mem_wait_finish();
        logic [5:0] exp_s [7] = '{6'b001111, 6'b001111, 6'b001111, 6'b011111, 6'b011111, 6'b0, 6'b0};
        for (int k = 0; k < 7; k++) begin
            drive(1'b0, (k < 6), 1'b0, (k == 3 || k == 4), 1'b0, 32'h0);
            @(negedge clk);
            n_checks++; if (stall !== exp_s[k])
                $display("FAIL memwait_stall k=%0d got %b exp %b", k, stall, exp_s[k]); else n_pass++;
            n_checks++; if (mc_finish !== (k >= 3 && k <= 5))
                $display("FAIL memwait_finish k=%0d got %b", k, mc_finish); else n_pass++;
            advance();
        end
        n_checks++; if (mc_busy !== 1'b0 || mc_finish !== 1'b0)
            $display("FAIL memwait_idle got busy=%b fin=%b exp 0/0", mc_busy, mc_finish); else n_pass++;
    endtask

    task automatic test_flush_abort();
        for (int k = 0; k < 13; k++) begin
            drive(1'b0, (k <= 10), 1'b1, 1'b0, (k == 10), (k == 10) ? 32'h0000_0100 : 32'hDEAD_BEEF);
            @(negedge clk);
            n_checks++; if (flush !== (k == 10)) $display("FAIL flush_flag k=%0d got %b", k, flush); else n_pass++;
            n_checks++; if (new_pc !== ((k == 10) ? 32'h0000_0100 : 32'h0))
                $display("FAIL flush_new_pc k=%0d got %h", k, new_pc); else n_pass++;
            n_checks++; if (stall !== ((k < 10) ? 6'b001111 : 6'b000000))
                $display("FAIL flush_stall k=%0d got %b", k, stall); else n_pass++;
            n_checks++; if (mc_finish !== 1'b0) $display("FAIL flush_finish k=%0d got %b exp 0", k, mc_finish); else n_pass++;
            if (k == 11) begin
                n_checks++; if (mc_busy !== 1'b0 || mc_cnt !== 6'd0)
                    $display("FAIL flush_idle got busy=%b cnt=%0d exp 0/0", mc_busy, mc_cnt); else n_pass++;
            end
            advance();
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] pc = $urandom;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, pc);
        @(negedge clk);
        n_checks++; if (stall !== 6'b011111 || flush !== 1'b0)
            $display("FAIL simul_mem got stall=%b flush=%b exp 011111/0", stall, flush); else n_pass++;
        advance();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, pc);
        @(negedge clk);
        n_checks++; if (stall !== 6'b000000 || flush !== 1'b1 || new_pc !== pc)
            $display("FAIL simul_flush got stall=%b flush=%b pc=%h exp 000000/1/%h", stall, flush, new_pc, pc); else n_pass++;
        advance();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset_mid_run();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        advance();
        for (int i = 0; i < 40 && m_hold_left != 20; i++) advance();
        n_checks++; if (mc_cnt !== 6'd20) $display("FAIL midrst_pre_cnt got %0d exp 20", mc_cnt); else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_checks++; if (stall !== 6'b0 || mc_busy !== 1'b0 || mc_cnt !== 6'd0)
            $display("FAIL midrst_async got stall=%b busy=%b cnt=%0d exp 0/0/0", stall, mc_busy, mc_cnt); else n_pass++;
        model_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (mc_busy !== 1'b0 || mc_finish !== 1'b0 || stall !== 6'b0)
            $display("FAIL midrst_idle got busy=%b fin=%b stall=%b", mc_busy, mc_finish, stall); else n_pass++;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        n_checks++; if (stall !== 6'b001111) $display("FAIL midrst_restart got %b exp 001111", stall); else n_pass++;
        advance();
        n_checks++; if (mc_busy !== 1'b1 || mc_cnt !== 6'd2)
            $display("FAIL midrst_run got busy=%b cnt=%0d exp 1/2", mc_busy, mc_cnt); else n_pass++;
        ex_mc_start = 1'b0;
        for (int i = 0; i < 10 && (m_hold_left > 0 || m_fin); i++) advance();
    endtask

    task automatic test_random();
        logic [5:0] es;
        for (int i = 0; i < 500; i++) begin
            drive(($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 15),
                  ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 4), $urandom);
            @(negedge clk);
            es = exp_stall();
            n_checks++; if (stall !== es) $display("FAIL rnd_stall i=%0d got %b exp %b", i, stall, es); else n_pass++;
            n_checks++; if (flush !== flush_req || new_pc !== (flush_req ? flush_pc_i : 32'h0))
                $display("FAIL rnd_flush i=%0d got %b/%h", i, flush, new_pc); else n_pass++;
            n_checks++; if (mc_busy !== (m_hold_left > 0) || mc_cnt !== CNT_W'(m_hold_left))
                $display("FAIL rnd_busy i=%0d got %b/%0d exp %b/%0d", i, mc_busy, mc_cnt, (m_hold_left > 0), m_hold_left); else n_pass++;
            n_checks++; if (mc_finish !== m_fin) $display("FAIL rnd_finish i=%0d got %b exp %b", i, mc_finish, m_fin); else n_pass++;
            n_checks++; if (stall_cycles !== 32'(m_sc))
                $display("FAIL rnd_stall_cycles i=%0d got %0d exp %0d", i, stall_cycles, m_sc); else n_pass++;
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_divide();
        test_mem_wait_finish();
        test_flush_abort();
        test_simultaneous();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
